// File: rtl/tcam_pkg.sv
// Shared op-codes and FSM state type for the TCAM controller.
package tcam_pkg;

    localparam logic [1:0] OP_WRITE  = 2'b00;
    localparam logic [1:0] OP_SEARCH = 2'b01;
    localparam logic [1:0] OP_INV    = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_SEARCH,
        ST_RESP
    } state_t;

endpackage

// File: rtl/tcam_if.sv
// Command/response handshake bundle between a requester and the TCAM controller.
interface tcam_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [IDX_W-1:0]  cmd_idx;
    logic [DATA_W-1:0] cmd_key;
    logic [DATA_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [IDX_W-1:0]  rsp_idx;

    modport master (
        output cmd_valid, cmd_op, cmd_idx, cmd_key, cmd_mask, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_hit, rsp_idx
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_idx, cmd_key, cmd_mask, rsp_ready,
        output cmd_ready, rsp_valid, rsp_hit, rsp_idx
    );

endinterface

// File: rtl/tcam_entry_match.sv
// Combinational ternary compare of one stored entry against a search key.
module tcam_entry_match #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] key_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic [DATA_W-1:0] mask_i,
    input  logic              valid_i,
    output logic              match_o
);

    assign match_o = valid_i && (((key_i ^ value_i) & mask_i) == '0);

endmodule

// File: rtl/tcam_ctrl.sv
// Sequential-scan TCAM controller: one entry compared per cycle, lowest index wins.
module tcam_ctrl
    import tcam_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    tcam_if.slave bus
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t            state_q;
    logic [1:0]        op_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  scan_q;
    logic [DATA_W-1:0] key_q;
    logic [DATA_W-1:0] mask_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic [IDX_W-1:0]  rsp_idx_q;

    logic [DATA_W-1:0] value_mem [DEPTH];
    logic [DATA_W-1:0] mask_mem  [DEPTH];
    logic [DEPTH-1:0]  valid_q;

    logic              scan_match;
    logic              write_en;

    assign write_en = (state_q == ST_WRITE);

    tcam_entry_match #(.DATA_W(DATA_W)) u_match (
        .key_i   (key_q),
        .value_i (value_mem[scan_q]),
        .mask_i  (mask_mem[scan_q]),
        .valid_i (valid_q[scan_q]),
        .match_o (scan_match)
    );

    // RESP spends one cycle raising rsp_valid, so outputs trail the state by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            idx_q       <= '0;
            scan_q      <= '0;
            key_q       <= '0;
            mask_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q        <= bus.cmd_op;
                        idx_q       <= bus.cmd_idx;
                        key_q       <= bus.cmd_key;
                        mask_q      <= bus.cmd_mask;
                        scan_q      <= '0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= (bus.cmd_op == OP_SEARCH) ? ST_SEARCH : ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    rsp_hit_q <= 1'b0;
                    rsp_idx_q <= idx_q;
                    state_q   <= ST_RESP;
                end
                ST_SEARCH: begin
                    if (scan_match) begin
                        rsp_hit_q <= 1'b1;
                        rsp_idx_q <= scan_q;
                        state_q   <= ST_RESP;
                    end else if (scan_q == LAST_IDX) begin
                        rsp_hit_q <= 1'b0;
                        rsp_idx_q <= '0;
                        state_q   <= ST_RESP;
                    end else begin
                        scan_q <= scan_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (write_en) begin
            if (op_q == OP_WRITE) begin
                valid_q[idx_q] <= 1'b1;
            end else if (op_q == OP_INV) begin
                valid_q[idx_q] <= 1'b0;
            end
        end
    end

    // Value/mask carry no reset; the valid flag alone gates matching.
    always_ff @(posedge clk) begin
        if (write_en && (op_q == OP_WRITE)) begin
            value_mem[idx_q] <= key_q;
            mask_mem[idx_q]  <= mask_q;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_idx   = rsp_idx_q;

endmodule

// File: tb/tb_tcam_ctrl.sv
// Directed plus randomized bench for tcam_ctrl against a flat-array TCAM model.
module tb_tcam_ctrl;
    import tcam_pkg::*;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [DATA_W-1:0] mValue [DEPTH];
    logic [DATA_W-1:0] mMask  [DEPTH];
    bit                mValid [DEPTH];

    always #5 clk = ~clk;

    tcam_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    tcam_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Lowest-index ternary match over the model table.
    function automatic void modelSearch(input logic [DATA_W-1:0] key, output bit hit, output int idx);
        hit = 1'b0;
        idx = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && mValid[i] && (((key ^ mValue[i]) & mMask[i]) == 0)) begin
                hit = 1'b1;
                idx = i;
            end
        end
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input int idx, input logic [DATA_W-1:0] key,
                                 input logic [DATA_W-1:0] mask, input int holdCycles);
        bit hit;
        int mIdx;
        int expLat;
        int lat;
        int waitCnt;
        logic expHit;
        logic [IDX_W-1:0] expIdx;

        if (op == OP_SEARCH) begin
            modelSearch(key, hit, mIdx);
            expHit = hit;
            expIdx = hit ? IDX_W'(mIdx) : '0;
            expLat = hit ? 2 + mIdx : 1 + DEPTH;
        end else begin
            expHit = 1'b0;
            expIdx = IDX_W'(idx);
            expLat = 2;
            if (op == OP_WRITE) begin
                mValue[idx] = key;
                mMask[idx]  = mask;
                mValid[idx] = 1'b1;
            end else if (op == OP_INV) begin
                mValid[idx] = 1'b0;
            end
        end

        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_idx   = IDX_W'(idx);
        bus.cmd_key   = key;
        bus.cmd_mask  = mask;
        waitCnt = 0;
        while (!bus.cmd_ready && waitCnt < 50) begin
            tick();
            waitCnt++;
        end
        if (!bus.cmd_ready) begin
            checkOutput("readyTimeout", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom_range(0, 3));
        bus.cmd_idx   = IDX_W'($urandom_range(0, DEPTH - 1));
        bus.cmd_key   = DATA_W'($urandom_range(0, 255));
        bus.cmd_mask  = DATA_W'($urandom_range(0, 255));

        lat = 0;
        do begin
            checkOutput("busyCmdReady", 32'(bus.cmd_ready), 32'd0);
            tick();
            lat++;
        end while (!bus.rsp_valid && lat < DEPTH + 8);
        if (!bus.rsp_valid) lat = 999;

        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("rspHit", 32'(bus.rsp_hit), 32'(expHit));
        checkOutput("rspIdx", 32'(bus.rsp_idx), 32'(expIdx));

        for (int c = 0; c < holdCycles; c++) begin
            tick();
            checkOutput("holdValid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("holdHit", 32'(bus.rsp_hit), 32'(expHit));
            checkOutput("holdIdx", 32'(bus.rsp_idx), 32'(expIdx));
            checkOutput("holdCmdReady", 32'(bus.cmd_ready), 32'd0);
        end

        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        checkOutput("postValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("postCmdReady", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        int sawValid;
        logic [1:0] rop;
        logic [DATA_W-1:0] rmask;

        for (int i = 0; i < DEPTH; i++) begin
            mValue[i] = '0;
            mMask[i]  = '0;
            mValid[i] = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_WRITE;
        bus.cmd_idx   = '0;
        bus.cmd_key   = '0;
        bus.cmd_mask  = '0;
        bus.rsp_ready = 1'b0;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("resetCmdReady", 32'(bus.cmd_ready), 32'd1);
        checkOutput("resetRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("resetRspHit", 32'(bus.rsp_hit), 32'd0);
        checkOutput("resetRspIdx", 32'(bus.rsp_idx), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] directed sequence");
        applyStimulus(OP_SEARCH, 0, 8'h5A, 8'h00, 0);
        applyStimulus(OP_WRITE, 3, 8'h50, 8'hF0, 0);
        applyStimulus(OP_SEARCH, 0, 8'h5A, 8'h00, 0);
        applyStimulus(OP_WRITE, 7, 8'h00, 8'h00, 0);
        applyStimulus(OP_WRITE, 2, 8'h11, 8'hFF, 0);
        applyStimulus(OP_SEARCH, 0, 8'h11, 8'h00, 0);
        applyStimulus(OP_SEARCH, 0, 8'h22, 8'h00, 0);
        applyStimulus(OP_INV, 7, 8'h00, 8'h00, 0);
        applyStimulus(OP_WRITE, 2, 8'hA5, 8'hFF, 0);
        applyStimulus(OP_INV, 2, 8'h00, 8'h00, 0);
        applyStimulus(OP_SEARCH, 0, 8'hA5, 8'h00, 0);
        applyStimulus(OP_WRITE, 15, 8'hC3, 8'hFF, 10);
        applyStimulus(OP_SEARCH, 0, 8'hC3, 8'h00, 10);
        applyStimulus(OP_RSVD, 15, 8'h00, 8'h00, 0);
        applyStimulus(OP_SEARCH, 0, 8'hC3, 8'h00, 0);

        $display("[TB] random sequence");
        for (int n = 0; n < 80; n++) begin
            rop = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) rop = OP_SEARCH;
            case ($urandom_range(0, 3))
                0:       rmask = 8'hFF;
                1:       rmask = 8'hF0;
                2:       rmask = 8'h0F;
                default: rmask = DATA_W'($urandom_range(0, 255));
            endcase
            applyStimulus(rop, int'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom_range(0, 255)),
                          rmask, int'($urandom_range(0, 2)));
        end

        $display("[TB] reset during search");
        applyStimulus(OP_WRITE, 9, 8'h00, 8'h00, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SEARCH;
        bus.cmd_key   = 8'h3C;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abortRspValid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("abortCmdReady", 32'(bus.cmd_ready), 32'd1);
        for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        sawValid = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (bus.rsp_valid) sawValid++;
        end
        checkOutput("abortNoResponse", 32'(sawValid), 32'd0);
        checkOutput("releaseCmdReady", 32'(bus.cmd_ready), 32'd1);
        applyStimulus(OP_SEARCH, 0, 8'h3C, 8'h00, 0);
        applyStimulus(OP_SEARCH, 0, 8'hC3, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcam_ctrl.md
TCAM_CTRL -- requirements
Module: tcam_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, key/value/mask width in bits.
REQ-002 Parameter DEPTH, default 16, entry count; SHALL be a power of two, minimum 2; IDX_W = log2(DEPTH).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command offered.
REQ-006 cmd_ready  out  1  controller accepts command this cycle.
REQ-007 cmd_op  in  2  00 WRITE, 01 SEARCH, 10 INVALIDATE, 11 reserved.
REQ-008 cmd_idx  in  IDX_W  target entry for WRITE/INVALIDATE.
REQ-009 cmd_key  in  DATA_W  value for WRITE, search key for SEARCH.
REQ-010 cmd_mask  in  DATA_W  care mask for WRITE: bit 1 = compare, bit 0 = don't-care.
REQ-011 rsp_valid  out  1  response available.
REQ-012 rsp_ready  in  1  response consumed.
REQ-013 rsp_hit  out  1  SEARCH matched.
REQ-014 rsp_idx  out  IDX_W  matching index (SEARCH hit) or cmd_idx (WRITE/INVALIDATE).

Function
REQ-015 Storage: per entry a DATA_W value, DATA_W mask and 1-bit valid flag, all registered.
REQ-016 Entry i matches key k iff valid[i] and ((k XOR value[i]) AND mask[i]) == 0.
REQ-017 FSM states: IDLE, WRITE, SEARCH, RESP; cmd_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-018 Command accepted on an edge where cmd_valid and cmd_ready are both 1; op, idx, key, mask are captured at that edge.
REQ-019 WRITE: in the WRITE cycle, value, mask and valid = 1 are written to the captured index; next state RESP with rsp_hit = 0, rsp_idx = captured idx.
REQ-020 INVALIDATE: uses the WRITE state; clears valid only, leaving value and mask unchanged; response as REQ-019.
REQ-021 Reserved op: treated as INVALIDATE-free no-op; passes through WRITE without modifying storage; response rsp_hit = 0.
REQ-022 SEARCH: scan counter starts at 0; one entry is compared per cycle in ascending index order.
REQ-023 A hit at index i SHALL stop the scan; RESP follows with rsp_hit = 1, rsp_idx = i; the lowest matching index always wins.
REQ-024 No hit through index DEPTH-1 SHALL give RESP with rsp_hit = 0, rsp_idx = 0.
REQ-025 Latency, with command accepted at edge T:
  - WRITE/INVALIDATE: rsp_valid high after edge T+2.
  - SEARCH hit at i: rsp_valid high after edge T+2+i.
  - SEARCH miss: rsp_valid high after edge T+1+DEPTH.
REQ-026 RESP holds rsp_valid, rsp_hit and rsp_idx stable until rsp_valid and rsp_ready are both 1 at an edge; next state IDLE; no back-to-back command in the same cycle.
REQ-027 Storage is not modified during SEARCH or RESP; cmd_* inputs are ignored outside IDLE.
REQ-028 The scan counter SHALL NOT wrap; the terminal index DEPTH-1 ends the scan.

Reset
REQ-029 On rst_n low, immediately and independent of clk:
  - all valid flags = 0; state = IDLE; scan counter = 0.
  - rsp_valid = 0, rsp_hit = 0, rsp_idx = 0; cmd_ready = 1 once in IDLE.
REQ-030 Value and mask arrays need not be reset.
REQ-031 Reset during WRITE, SEARCH or RESP aborts the operation with no response issued; a WRITE aborted by reset leaves the entry invalid.

Structure
REQ-032 Shared package tcam_pkg SHALL hold the op-code constants (OP_WRITE, OP_SEARCH, OP_INV) and the FSM state typedef.
REQ-033 Sub-module tcam_entry_match SHALL be a combinational per-entry ternary compare (key, value, mask, valid -> match), instantiated once on the scan path.

Verification
REQ-034 Reset then SEARCH key 0x5A -> miss: rsp_hit = 0, rsp_idx = 0, rsp_valid exactly DEPTH+1 cycles after accept.
REQ-035 WRITE idx 3 value 0x50 mask 0xF0; SEARCH 0x5A -> rsp_hit = 1, rsp_idx = 3, rsp_valid 5 cycles after accept.
REQ-036 WRITE idx 7 mask 0x00 and idx 2 value 0x11 mask 0xFF; SEARCH 0x11 -> idx 2; SEARCH 0x22 -> idx 7.
REQ-037 WRITE idx 2, INVALIDATE idx 2, then SEARCH the same key -> miss.
REQ-038 Hold rsp_ready = 0 for 10 cycles in RESP -> outputs stable and cmd_ready = 0 throughout; accept only after handshake.
REQ-039 Assert rst_n low mid-SEARCH -> rsp_valid never asserts, all entries invalid, cmd_ready = 1 after release.
